// File: rtl/color_unhash.sv
// Brute-force inverse of the colour hash: finds the lowest key whose iterated hash equals the target.
// Optional result cache enabled by defining UNHASH_CACHE_EN.
module color_unhash #(
   parameter logic [31:0] HASH_BASE = 32'd5381,
   parameter logic [31:0] MULT      = 32'd33,
   parameter int          KEY_SIZE  = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [31:0]         target_hash,
   output logic                busy,
   output logic                done,
   output logic                found,
   output logic [KEY_SIZE-1:0] key
);

   localparam int RW = (KEY_SIZE > 1) ? KEY_SIZE - 1 : 1;
   localparam logic [RW-1:0]       ROUND_LAST = RW'((2 ** (KEY_SIZE - 1)) - 1);
   localparam logic [KEY_SIZE-1:0] LAST_KEY   = '1;

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_CHECK, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [31:0]         target_q, target_d;
   logic [31:0]         h_q, h_d;
   logic [KEY_SIZE-1:0] k_q, k_d;
   logic [KEY_SIZE-1:0] c_q, c_d;
   logic [KEY_SIZE-1:0] c_inc;
   logic [RW-1:0]       round_q, round_d;
   logic                found_q, found_d;
   logic [KEY_SIZE-1:0] key_q, key_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
`ifdef UNHASH_CACHE_EN
   logic                cache_valid_q, cache_valid_d;
   logic [31:0]         cache_target_q, cache_target_d;
   logic                cache_found_q, cache_found_d;
   logic [KEY_SIZE-1:0] cache_key_q, cache_key_d;
`endif

   assign c_inc = c_q + 1'b1;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      h_d      = h_q;
      k_d      = k_q;
      c_d      = c_q;
      round_d  = round_q;
      found_d  = found_q;
      key_d    = key_q;
`ifdef UNHASH_CACHE_EN
      cache_valid_d  = cache_valid_q;
      cache_target_d = cache_target_q;
      cache_found_d  = cache_found_q;
      cache_key_d    = cache_key_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               target_d = target_hash;
               k_d      = '0;
               c_d      = '0;
               h_d      = HASH_BASE;
               round_d  = '0;
               found_d  = 1'b0;
               key_d    = '0;
               state_d  = S_ROUND;
`ifdef UNHASH_CACHE_EN
               if (cache_valid_q && (target_hash == cache_target_q)) begin
                  found_d = cache_found_q;
                  key_d   = cache_key_q;
                  state_d = S_DONE;
               end
`endif
            end
         end
         S_ROUND: begin
            c_d     = c_inc;
            h_d     = h_q * MULT + 32'(c_inc);
            round_d = round_q + 1'b1;
            if (round_q == ROUND_LAST) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (h_q == target_q) begin
               found_d = 1'b1;
               key_d   = k_q;
               state_d = S_DONE;
            end else if (k_q == LAST_KEY) begin
               // Explicit last-candidate test keeps k from wrapping into a second pass.
               found_d = 1'b0;
               key_d   = '0;
               state_d = S_DONE;
            end else begin
               k_d     = k_q + 1'b1;
               c_d     = k_q + 1'b1;
               h_d     = HASH_BASE;
               round_d = '0;
               state_d = S_ROUND;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
`ifdef UNHASH_CACHE_EN
            cache_valid_d  = 1'b1;
            cache_target_d = target_q;
            cache_found_d  = found_q;
            cache_key_d    = key_q;
`endif
         end
         default: state_d = S_IDLE;
      endcase
      done_d = (state_d == S_DONE);
      busy_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         target_q <= '0;
         h_q      <= '0;
         k_q      <= '0;
         c_q      <= '0;
         round_q  <= '0;
         found_q  <= 1'b0;
         key_q    <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         h_q      <= h_d;
         k_q      <= k_d;
         c_q      <= c_d;
         round_q  <= round_d;
         found_q  <= found_d;
         key_q    <= key_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

`ifdef UNHASH_CACHE_EN
   // NOTE: only the valid bit is reset; cache payload is never read while invalid.
   always_ff @(posedge clk) begin
      if (reset) cache_valid_q <= 1'b0;
      else       cache_valid_q <= cache_valid_d;
      cache_target_q <= cache_target_d;
      cache_found_q  <= cache_found_d;
      cache_key_q    <= cache_key_d;
   end
`endif

   assign busy  = busy_q;
   assign done  = done_q;
   assign found = found_q;
   assign key   = key_q;

endmodule

// File: tb/tb_color_unhash.sv
// Self-checking bench for color_unhash: vector table plus scoreboard of expected results.
module tb_color_unhash;
   localparam int          KS = 6;
   localparam logic [31:0] HB = 32'd5381;
   localparam logic [31:0] ML = 32'd33;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [31:0]   target_hash;
   logic          busy, done, found;
   logic [KS-1:0] key;

   color_unhash #(.HASH_BASE(HB), .MULT(ML), .KEY_SIZE(KS)) dut (
      .clk(clk), .reset(reset), .start(start), .target_hash(target_hash),
      .busy(busy), .done(done), .found(found), .key(key)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0]   target;
      logic          found;
      logic [KS-1:0] key;
      int            lat;
   } exp_t;

   typedef struct {
      int          key_idx;   // -1 selects the absent target
      logic        exp_found;
      logic [KS-1:0] exp_key;
      int          intr_at;
      logic        intr_done;
      int          hold;
   } vec_t;

   exp_t        sb[$];
   logic        m_cache_valid = 1'b0;
   logic [31:0] m_cache_target;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] golden(input int k);
      logic [KS-1:0] c;
      logic [31:0]   h;
      c = KS'(k);
      h = HB;
      for (int r = 0; r < 2 ** (KS - 1); r++) begin
         c = c + 1'b1;
         h = h * ML + 32'(c);
      end
      return h;
   endfunction

   function automatic exp_t model(input logic [31:0] t);
      exp_t e;
      e.target = t;
      e.found  = 1'b0;
      e.key    = '0;
      e.lat    = 1 + 33 * (2 ** KS);
      for (int k = 2 ** KS - 1; k >= 0; k--) begin
         if (golden(k) == t) begin
            e.found = 1'b1;
            e.key   = KS'(k);
            e.lat   = 1 + 33 * (k + 1);
         end
      end
`ifdef UNHASH_CACHE_EN
      if (m_cache_valid && t == m_cache_target) e.lat = 1;
`endif
      return e;
   endfunction

   task automatic start_search(input logic [31:0] t, output int t_edge);
      @(negedge clk);
      target_hash = t;
      start       = 1'b1;
      t_edge      = cyc + 1;
      sb.push_back(model(t));
      @(negedge clk);
      start       = 1'b0;
      target_hash = ~t;
      check("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(input string name, input int t_edge, input int intr_at,
                            input logic [31:0] intr_t, input logic intr_done, output exp_t e);
      int lat;
      lat = -1;
      for (int n = 0; n < 3000; n++) begin
         if (done) begin
            lat = cyc + 1 - t_edge;
            break;
         end
         if (intr_at >= 0 && (cyc + 1 - t_edge) == intr_at) begin
            start = 1'b1;
            target_hash = intr_t;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      e = sb.pop_front();
      if (lat < 0) begin
         errors++;
         $display("FAIL %s_timeout: no done within bound", name);
         return;
      end
      check({name, "_latency"}, lat, e.lat);
      check({name, "_found"}, found, e.found);
      check({name, "_key"}, key, e.key);
      if (intr_done) begin
         start = 1'b1;
         target_hash = intr_t;
      end
      m_cache_valid  = 1'b1;
      m_cache_target = e.target;
      @(negedge clk);
      start = 1'b0;
      check({name, "_done_pulse"}, done, 0);
      check({name, "_busy_clear"}, busy, 0);
   endtask

   task automatic hold_check(input string name, input int n, input exp_t e);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (found !== e.found || key !== e.key || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      check({name, "_hold"}, bad, 0);
   endtask

   initial begin
      vec_t        vecs[5];
      logic [31:0] miss_t;
      logic [31:0] t;
      logic        hit;
      int          t_edge;
      logic        done_seen;
      exp_t        e;

      reset = 1'b1;
      start = 1'b0;
      target_hash = '0;

      miss_t = 32'hDEADBEEF;
      do begin
         hit = 1'b0;
         for (int k = 0; k < 2 ** KS; k++) if (golden(k) == miss_t) hit = 1'b1;
         if (hit) miss_t = miss_t + 1;
      end while (hit);

      //       key  found key intr_at intr_done hold
      vecs[0] = '{0,  1'b1, 6'd0,  -1, 1'b0,   5};
      vecs[1] = '{37, 1'b1, 6'd37, -1, 1'b0, 100};
      vecs[2] = '{-1, 1'b0, 6'd0,  -1, 1'b0,   5};
      vecs[3] = '{2,  1'b1, 6'd2,  10, 1'b1,   0};
      vecs[4] = '{1,  1'b1, 6'd1,  -1, 1'b0,   5};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_found", found, 0);
      check("rst_key", key, 0);

      for (int i = 0; i < 5; i++) begin
         t = (vecs[i].key_idx < 0) ? miss_t : golden(vecs[i].key_idx);
         start_search(t, t_edge);
         check($sformatf("vec%0d_table_found", i), sb[0].found, vecs[i].exp_found);
         check($sformatf("vec%0d_table_key", i), sb[0].key, vecs[i].exp_key);
         wait_done($sformatf("vec%0d", i), t_edge, vecs[i].intr_at, golden(0), vecs[i].intr_done, e);
         if (vecs[i].hold > 0) hold_check($sformatf("vec%0d", i), vecs[i].hold, e);
      end

      // Reset in the middle of a long search must abort with no done pulse.
      start_search(golden(63), t_edge);
      done_seen = 1'b0;
      while (cyc + 1 < t_edge + 500) begin
         @(negedge clk);
         if (done) done_seen = 1'b1;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_found", found, 0);
      check("abort_key", key, 0);
      sb.delete();
      m_cache_valid = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done || busy) done_seen = 1'b1;
      end
      check("abort_no_done", done_seen, 0);

      start_search(golden(5), t_edge);
      wait_done("after_abort_k5", t_edge, -1, '0, 1'b0, e);

      // Repeat target: served from cache when enabled, full search otherwise.
      start_search(golden(37), t_edge);
      wait_done("repeat_a", t_edge, -1, '0, 1'b0, e);
      start_search(golden(37), t_edge);
      wait_done("repeat_b", t_edge, -1, '0, 1'b0, e);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_cache_valid = 1'b0;
      start_search(golden(37), t_edge);
      wait_done("repeat_after_reset", t_edge, -1, '0, 1'b0, e);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
